// File: rtl/fft4_dit_feeder.sv
// -----------------------------------------------------------------------------
// fft4_dit_feeder
// Input stage of the 4-point DIT/IDIT datapath. Complex samples arrive one at
// a time over a valid/ready handshake and are gathered four at a time into a
// ping-pong buffer (2 banks x 4 entries). Each complete frame is presented to
// the first-stage butterfly as two bit-reversed operand pairs:
//   pair 0 = (x0, x2), pair 1 = (x1, x3)
// together with the stage-1 twiddle (WUNITY, 0). Values are passed through
// bit-exact; no arithmetic is performed.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                synchronous active-low reset
//   in_valid / in_ready  sample handshake, sample on in_r / in_i (signed DW)
//   out_valid / out_ready operand pair handshake
//   out_xr, out_xi       butterfly top input (x0 or x1)
//   out_yr, out_yi       butterfly bottom input (x2 or x3)
//   out_wr, out_wi       stage-1 twiddle (WUNITY, 0)
//   out_pair             0 = (x0,x2), 1 = (x1,x3)
//   out_last             high with pair 1 (last pair of a frame)
//   out_tag              frame index, increments per frame issued
// -----------------------------------------------------------------------------
module fft4_dit_feeder #(
  parameter int DW     = 9,
  parameter int WUNITY = 255,
  parameter int TAGW   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_r,
  input  logic signed [DW-1:0]   in_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW-1:0]   out_xr,
  output logic signed [DW-1:0]   out_xi,
  output logic signed [DW-1:0]   out_yr,
  output logic signed [DW-1:0]   out_yi,
  output logic signed [DW-1:0]   out_wr,
  output logic signed [DW-1:0]   out_wi,
  output logic                   out_pair,
  output logic                   out_last,
  output logic [TAGW-1:0]        out_tag
);

  localparam logic signed [DW-1:0] W_RE = DW'(WUNITY);

  // Ping-pong storage: [bank][entry]
  logic signed [DW-1:0] mem_r [2][4];
  logic signed [DW-1:0] mem_i [2][4];

  logic [1:0]      full;
  logic            wbank;
  logic [1:0]      wcnt;
  logic            rbank;
  logic            rsel;
  logic [TAGW-1:0] tag;

  logic            wr_fire;
  logic            rd_fire;
  logic [1:0]      x_idx;
  logic [1:0]      y_idx;

  // Gating with rst_n keeps both handshakes quiet for the whole reset
  // window, including the first cycle before the reset edge clears state.
  assign in_ready  = rst_n & ~full[wbank];
  assign out_valid = rst_n & full[rbank];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  // Bit-reversed pairing: rsel picks entry 0/1 for x and entry 2/3 for y.
  assign x_idx = {1'b0, rsel};
  assign y_idx = {1'b1, rsel};

  // Sample storage is deliberately not reset; the full flags decide whether
  // any of it is ever looked at.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_r[wbank][wcnt] <= in_r;
      mem_i[wbank][wcnt] <= in_i;
    end
  end

  // Bank bookkeeping. The writer and reader always sit on different banks
  // while both are active, so setting one full flag and clearing the other
  // in the same cycle never collides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      wcnt  <= 2'd0;
      rbank <= 1'b0;
      rsel  <= 1'b0;
      tag   <= '0;
    end else begin
      if (wr_fire) begin
        if (wcnt == 2'd3) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          wcnt        <= 2'd0;
        end else begin
          wcnt <= wcnt + 2'd1;
        end
      end
      if (rd_fire) begin
        if (rsel) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          rsel        <= 1'b0;
          tag         <= tag + 1'b1;
        end else begin
          rsel <= 1'b1;
        end
      end
    end
  end

  // Output fields are zero whenever no pair is offered, so a stalled or
  // empty feeder never shows stale data downstream.
  always_comb begin
    out_xr   = '0;
    out_xi   = '0;
    out_yr   = '0;
    out_yi   = '0;
    out_wr   = '0;
    out_wi   = '0;
    out_pair = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      out_xr   = mem_r[rbank][x_idx];
      out_xi   = mem_i[rbank][x_idx];
      out_yr   = mem_r[rbank][y_idx];
      out_yi   = mem_i[rbank][y_idx];
      out_wr   = W_RE;
      out_wi   = '0;
      out_pair = rsel;
      out_last = rsel;
    end
  end

  assign out_tag = tag;

endmodule

// File: tb/tb_fft4_dit_feeder.sv
// -----------------------------------------------------------------------------
// tb_fft4_dit_feeder
// Self-checking bench for fft4_dit_feeder. A behavioural model keeps whole
// frames in a queue (capacity two) and a partial-frame queue; expected
// outputs come from the head frame of that queue. A short table of directed
// vectors covers the basic frame, followed by stall, continuous, random,
// reset and tag-wrap sequences.
// -----------------------------------------------------------------------------
module tb_fft4_dit_feeder;

  localparam int DW     = 9;
  localparam int WUNITY = 255;
  localparam int TAGW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_r;
  logic [DW-1:0]   in_i;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_xr;
  logic [DW-1:0]   out_xi;
  logic [DW-1:0]   out_yr;
  logic [DW-1:0]   out_yi;
  logic [DW-1:0]   out_wr;
  logic [DW-1:0]   out_wi;
  logic            out_pair;
  logic            out_last;
  logic [TAGW-1:0] out_tag;

  fft4_dit_feeder #(.DW(DW), .WUNITY(WUNITY), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xr    (out_xr),
    .out_xi    (out_xi),
    .out_yr    (out_yr),
    .out_yi    (out_yi),
    .out_wr    (out_wr),
    .out_wi    (out_wi),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .out_tag   (out_tag)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: each sample is {r, i}; a frame is four samples in
  // arrival order. fq holds complete frames awaiting issue (at most two).
  typedef logic [3:0][17:0] frame_t;
  frame_t      fq[$];
  logic [17:0] part[$];
  int          rsel_m;
  int          tag_m;
  logic        last_acc;

  typedef struct packed {
    logic        v;
    logic [17:0] s;
    logic        ordy;
    logic        e_ready;
    logic        e_valid;
    logic [17:0] e_x;
    logic [17:0] e_y;
    logic        e_pair;
    logic        e_last;
    logic [3:0]  e_tag;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(logic v, logic [17:0] s, logic ordy, logic er,
                              logic ev, logic [17:0] ex, logic [17:0] ey,
                              logic ep, logic el, logic [3:0] et);
    vec_t t;
    t.v = v; t.s = s; t.ordy = ordy; t.e_ready = er; t.e_valid = ev;
    t.e_x = ex; t.e_y = ey; t.e_pair = ep; t.e_last = el; t.e_tag = et;
    return t;
  endfunction

  function automatic logic [17:0] smp(int r, int i);
    logic [8:0] rr;
    logic [8:0] ii;
    rr = 9'(r);
    ii = 9'(i);
    return {rr, ii};
  endfunction

  function automatic logic [17:0] rand_samp();
    logic [8:0] r;
    logic [8:0] i;
    case ($urandom_range(0, 3))
      0:       r = 9'h100;
      1:       r = 9'h0FF;
      default: r = 9'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       i = 9'h0FF;
      1:       i = 9'h100;
      default: i = 9'($urandom);
    endcase
    return {r, i};
  endfunction

  function automatic logic m_ready();
    return (rst_n === 1'b1) && (fq.size() < 2);
  endfunction

  function automatic logic m_valid();
    return (rst_n === 1'b1) && (fq.size() > 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic v,
                               input logic [17:0] s, input logic ordy);
    rst_n     = rn;
    in_valid  = v;
    in_r      = s[17:9];
    in_i      = s[8:0];
    out_ready = ordy;
  endtask

  // Compare every DUT output against the model's view of the current cycle.
  task automatic checkModel();
    logic        v;
    logic [17:0] xs;
    logic [17:0] ys;
    v  = m_valid();
    xs = '0;
    ys = '0;
    if (v) begin
      xs = fq[0][rsel_m];
      ys = fq[0][rsel_m + 2];
    end
    checkOutput("in_ready",  32'(in_ready),  32'(m_ready()));
    checkOutput("out_valid", 32'(out_valid), 32'(v));
    checkOutput("out_xr",    32'(out_xr),    32'(xs[17:9]));
    checkOutput("out_xi",    32'(out_xi),    32'(xs[8:0]));
    checkOutput("out_yr",    32'(out_yr),    32'(ys[17:9]));
    checkOutput("out_yi",    32'(out_yi),    32'(ys[8:0]));
    checkOutput("out_wr",    32'(out_wr),    v ? 32'(WUNITY) : 32'd0);
    checkOutput("out_wi",    32'(out_wi),    32'd0);
    checkOutput("out_pair",  32'(out_pair),  (v && rsel_m == 1) ? 32'd1 : 32'd0);
    checkOutput("out_last",  32'(out_last),  (v && rsel_m == 1) ? 32'd1 : 32'd0);
    checkOutput("out_tag",   32'(out_tag),   32'(tag_m % (1 << TAGW)));
  endtask

  // Advance one clock and update the model with the handshakes that fired.
  task automatic tick();
    logic pr;
    logic pv;
    logic acc;
    frame_t f;
    pr  = m_ready();
    pv  = m_valid();
    acc = 1'b0;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      fq.delete();
      part.delete();
      rsel_m = 0;
      tag_m  = 0;
    end else begin
      acc = in_valid && pr;
      if (pv && out_ready) begin
        if (rsel_m == 1) begin
          void'(fq.pop_front());
          rsel_m = 0;
          tag_m  = (tag_m + 1) % (1 << TAGW);
        end else begin
          rsel_m = 1;
        end
      end
      if (acc) begin
        part.push_back({in_r, in_i});
        if (part.size() == 4) begin
          for (int k = 0; k < 4; k++) f[k] = part[k];
          fq.push_back(f);
          part.delete();
        end
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic step(input logic rn, input logic v, input logic [17:0] s,
                      input logic ordy);
    applyStimulus(rn, v, s, ordy);
    #1;
    checkModel();
    tick();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int c = 0; c < n; c++) step(1'b1, 1'b0, 18'd0, ordy);
  endtask

  initial begin
    logic [17:0] src[12];
    logic [17:0] s4[4];
    logic [17:0] cur;
    logic        holding;
    int          k;

    rsel_m = 0;
    tag_m  = 0;

    // Establish reset before any comparison; DUT state is unknown here.
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
    tick();
    step(1'b0, 1'b1, smp(7, 7), 1'b1);
    step(1'b0, 1'b0, 18'd0, 1'b0);

    // Directed basic frame
    tbl[0] = mk(1, smp(1, -1), 1, 1, 0, 18'd0,       18'd0,       0, 0, 4'd0);
    tbl[1] = mk(1, smp(2, -2), 1, 1, 0, 18'd0,       18'd0,       0, 0, 4'd0);
    tbl[2] = mk(1, smp(3, -3), 1, 1, 0, 18'd0,       18'd0,       0, 0, 4'd0);
    tbl[3] = mk(1, smp(4, -4), 1, 1, 0, 18'd0,       18'd0,       0, 0, 4'd0);
    tbl[4] = mk(0, 18'd0,      1, 1, 1, smp(1, -1), smp(3, -3), 0, 0, 4'd0);
    tbl[5] = mk(0, 18'd0,      1, 1, 1, smp(2, -2), smp(4, -4), 1, 1, 4'd0);
    tbl[6] = mk(0, 18'd0,      1, 1, 0, 18'd0,       18'd0,       0, 0, 4'd1);
    for (int r = 0; r < 7; r++) begin
      applyStimulus(1'b1, tbl[r].v, tbl[r].s, tbl[r].ordy);
      #1;
      checkOutput("tbl_in_ready",  32'(in_ready),  32'(tbl[r].e_ready));
      checkOutput("tbl_out_valid", 32'(out_valid), 32'(tbl[r].e_valid));
      checkOutput("tbl_x",         32'({out_xr, out_xi}), 32'(tbl[r].e_x));
      checkOutput("tbl_y",         32'({out_yr, out_yi}), 32'(tbl[r].e_y));
      checkOutput("tbl_w",         32'({out_wr, out_wi}),
                  tbl[r].e_valid ? 32'({9'd255, 9'd0}) : 32'd0);
      checkOutput("tbl_pair",      32'(out_pair),  32'(tbl[r].e_pair));
      checkOutput("tbl_last",      32'(out_last),  32'(tbl[r].e_last));
      checkOutput("tbl_tag",       32'(out_tag),   32'(tbl[r].e_tag));
      tick();
    end

    // Back-pressure: 12 samples offered with out_ready low
    for (int j = 0; j < 12; j++) src[j] = rand_samp();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, src[k], 1'b0);
      if (last_acc) k++;
    end
    checkOutput("stall_accepts", 32'(k), 32'd8);
    for (int c = 0; c < 40 && (k < 12 || fq.size() > 0); c++) begin
      step(1'b1, k < 12, src[k % 12], 1'b1);
      if (last_acc) k++;
    end
    checkOutput("stall_drain_accepts", 32'(k), 32'd12);
    checkOutput("stall_drain_empty", 32'(fq.size()), 32'd0);

    // Continuous 8 frames at full rate, in_ready must never drop
    for (int c = 0; c < 32; c++) begin
      applyStimulus(1'b1, 1'b1, rand_samp(), 1'b1);
      #1;
      checkOutput("cont_in_ready", 32'(in_ready), 32'd1);
      checkModel();
      tick();
    end
    idle(3, 1'b1);

    // Random valid/ready with the source holding each sample until taken
    holding = 1'b0;
    cur     = rand_samp();
    for (int c = 0; c < 300; c++) begin
      logic v;
      v = holding ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, v, cur, 1'($urandom_range(0, 1)));
      holding = v && !last_acc;
      if (last_acc) cur = rand_samp();
    end
    idle(6, 1'b1);

    // Reset after two samples of a frame
    step(1'b1, 1'b1, rand_samp(), 1'b1);
    step(1'b1, 1'b1, rand_samp(), 1'b1);
    step(1'b0, 1'b0, 18'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_tag",   32'(out_tag),   32'd0);
    tick();

    // Reset while a full bank waits for out_ready
    for (int j = 0; j < 4; j++) step(1'b1, 1'b1, rand_samp(), 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
    #1;
    checkOutput("rst_full_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_full_tag",   32'(out_tag),   32'd0);
    tick();
    for (int j = 0; j < 4; j++) begin
      s4[j] = rand_samp();
      step(1'b1, 1'b1, s4[j], 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
    #1;
    checkOutput("rst_frame0_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_frame0_x", 32'({out_xr, out_xi}), 32'(s4[0]));
    checkOutput("rst_frame0_y", 32'({out_yr, out_yi}), 32'(s4[2]));
    checkOutput("rst_frame0_tag", 32'(out_tag), 32'd0);
    checkModel();
    tick();
    idle(3, 1'b1);

    // Tag wrap: 16 frames from reset bring the tag back to 0
    step(1'b0, 1'b0, 18'd0, 1'b1);
    for (int c = 0; c < 64; c++) begin
      step(1'b1, 1'b1, rand_samp(), 1'b1);
      if (c == 61) checkOutput("tag_before_wrap", 32'(out_tag), 32'd15);
    end
    idle(3, 1'b1);
    checkOutput("tag_wrap", 32'(out_tag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
